// File: rtl/instr_seq_pkg.sv
// -----------------------------------------------------------------------------
// instr_seq_pkg
// Shared types and default constants for the instrumented-adder sequencer.
//   seq_state_t        : sequencer FSM states (IDLE, LOAD, RUN, CAPTURE, RESP)
//   DEF_SETTLE_CYCLES  : default operand settle time before run asserts
//   DEF_MAX_CYCLES     : default run-phase watchdog limit
//   DEF_CNT_W          : default width of the elapsed-cycle counter
// -----------------------------------------------------------------------------
package instr_seq_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    RUN     = 3'd2,
    CAPTURE = 3'd3,
    RESP    = 3'd4
  } seq_state_t;

  localparam int unsigned DEF_SETTLE_CYCLES = 4;
  localparam int unsigned DEF_MAX_CYCLES    = 65535;
  localparam int unsigned DEF_CNT_W         = 32;

endpackage

// File: rtl/instr_adder_sequencer_sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// One-bit two-flop synchroniser with asynchronous active-low reset.
// Ports:
//   clk    in  destination clock
//   rst_n  in  asynchronous active-low reset (both flops clear to 0)
//   d      in  asynchronous input
//   q      out synchronised output
// -----------------------------------------------------------------------------
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/instr_adder_sequencer.sv
// -----------------------------------------------------------------------------
// instr_adder_sequencer
// Host-side controller for the instrumented Kogge-Stone adder. Takes one
// measurement command, loads the adder, waits SETTLE_CYCLES with run low,
// runs the ring oscillator until the (synchronised) done flag, captures the
// sum and ring count, and returns them with its own RUN cycle count over a
// valid/ready response channel.
//
// Optional build macro: INSTR_SEQ_TIMEOUT_EN
//   defined   : RUN is abandoned after MAX_CYCLES cycles without done; the
//               response is still produced with rsp_timeout=1.
//   undefined : no watchdog, rsp_timeout is constant 0.
//
// Ports:
//   wb_clk_i, wb_rst_n         clock, asynchronous active-low reset
//   cmd_valid/cmd_ready        command handshake
//   cmd_a, cmd_b               operands
//   cmd_ext_mask, cmd_ring_mask per-bit operand-a source selects
//   abort                      synchronous abort (LOAD/RUN/CAPTURE only)
//   add_a, add_b, add_ext_mask, add_ring_mask  registered command to adder
//   add_run                    adder ring/chain enable
//   add_done                   adder completion, asynchronous to wb_clk_i
//   add_sum, add_count         adder results
//   rsp_valid/rsp_ready        response handshake
//   rsp_sum, rsp_count         captured adder results
//   rsp_cycles                 wb_clk_i cycles spent in RUN (saturating)
//   rsp_timeout                watchdog fired
// -----------------------------------------------------------------------------
module instr_adder_sequencer
  import instr_seq_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int unsigned MAX_CYCLES    = DEF_MAX_CYCLES,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_a,
  input  logic [31:0]      cmd_b,
  input  logic [31:0]      cmd_ext_mask,
  input  logic [31:0]      cmd_ring_mask,
  input  logic             abort,
  output logic [31:0]      add_a,
  output logic [31:0]      add_b,
  output logic [31:0]      add_ext_mask,
  output logic [31:0]      add_ring_mask,
  output logic             add_run,
  input  logic             add_done,
  input  logic [31:0]      add_sum,
  input  logic [31:0]      add_count,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_sum,
  output logic [31:0]      rsp_count,
  output logic [CNT_W-1:0] rsp_cycles,
  output logic             rsp_timeout
);

  // Settle counter only has to reach SETTLE_CYCLES-1.
  localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  generate
    if (SETTLE_CYCLES < 1) begin : g_bad_settle
      $error("SETTLE_CYCLES must be at least 1");
    end
    if (MAX_CYCLES < 1) begin : g_bad_max
      $error("MAX_CYCLES must be at least 1");
    end
  endgenerate

  seq_state_t        state_reg, state_next;
  logic [SET_W-1:0]  settle_cnt_reg;
  logic [CNT_W-1:0]  cycle_cnt_reg;
  logic              timeout_reg;
  logic              add_run_reg, add_run_next;
  logic [31:0]       add_a_reg, add_b_reg, add_ext_reg, add_ring_reg;
  logic [31:0]       rsp_sum_reg, rsp_count_reg;
  logic              done_s;
  logic              wd_expired;
  logic              timeout_hit;
  logic              settle_last;

  sync_2ff u_done_sync (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_n),
    .d     (add_done),
    .q     (done_s)
  );

  assign settle_last = (settle_cnt_reg == SET_W'(SETTLE_CYCLES - 1));

  // The counter is incremented on the same edge that leaves RUN, so firing
  // when it holds MAX_CYCLES-1 makes the reported count exactly MAX_CYCLES.
`ifdef INSTR_SEQ_TIMEOUT_EN
  assign wd_expired = (cycle_cnt_reg == CNT_W'(MAX_CYCLES - 1));
`else
  assign wd_expired = 1'b0;
`endif

  // Next-state and control decode.
  always_comb begin
    state_next   = state_reg;
    cmd_ready    = 1'b0;
    rsp_valid    = 1'b0;
    timeout_hit  = 1'b0;
    case (state_reg)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_next = LOAD;
      end
      LOAD: begin
        // done_s is deliberately ignored here; it is only sampled in RUN.
        if (abort)            state_next = IDLE;
        else if (settle_last) state_next = RUN;
      end
      RUN: begin
        // Priority: abort, then done, then watchdog.
        if (abort)           state_next = IDLE;
        else if (done_s)     state_next = CAPTURE;
        else if (wd_expired) begin
          state_next  = CAPTURE;
          timeout_hit = 1'b1;
        end
      end
      CAPTURE: begin
        if (abort) state_next = IDLE;
        else       state_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // add_run is a flop so the ring enable is glitch-free; it is high exactly
  // while state_reg is RUN and clears asynchronously with reset.
  assign add_run_next = (state_next == RUN);

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_reg      <= IDLE;
      settle_cnt_reg <= '0;
      cycle_cnt_reg  <= '0;
      timeout_reg    <= 1'b0;
      add_run_reg    <= 1'b0;
      add_a_reg      <= '0;
      add_b_reg      <= '0;
      add_ext_reg    <= '0;
      add_ring_reg   <= '0;
      rsp_sum_reg    <= '0;
      rsp_count_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      add_run_reg <= add_run_next;

      if (state_reg == IDLE && cmd_valid) begin
        add_a_reg      <= cmd_a;
        add_b_reg      <= cmd_b;
        add_ext_reg    <= cmd_ext_mask;
        add_ring_reg   <= cmd_ring_mask;
        settle_cnt_reg <= '0;
        cycle_cnt_reg  <= '0;
        timeout_reg    <= 1'b0;
      end

      if (state_reg == LOAD) begin
        settle_cnt_reg <= settle_cnt_reg + SET_W'(1);
      end

      if (state_reg == RUN && cycle_cnt_reg != {CNT_W{1'b1}}) begin
        cycle_cnt_reg <= cycle_cnt_reg + CNT_W'(1);
      end

      if (timeout_hit) begin
        timeout_reg <= 1'b1;
      end

      // An aborted capture leaves the previous response fields untouched.
      if (state_reg == CAPTURE && !abort) begin
        rsp_sum_reg   <= add_sum;
        rsp_count_reg <= add_count;
      end
    end
  end

  assign add_a         = add_a_reg;
  assign add_b         = add_b_reg;
  assign add_ext_mask  = add_ext_reg;
  assign add_ring_mask = add_ring_reg;
  assign add_run       = add_run_reg;
  assign rsp_sum       = rsp_sum_reg;
  assign rsp_count     = rsp_count_reg;
  assign rsp_cycles    = cycle_cnt_reg;
  assign rsp_timeout   = timeout_reg;

endmodule
